// File: rtl/adc045_ctrl.sv
// ADC045 power-up sequencer, continuous-conversion capture and data-ready watchdog.
// Optional block averaging is enabled by defining ADC045_AVG_EN.
module adc045_ctrl #(
  parameter int RST_PULSE_CYC  = 16,
  parameter int RST_WAIT_CYC   = 1024,
  parameter int WREG_PULSE_CYC = 4,
  parameter int WREG_WAIT_CYC  = 256,
  parameter int TIMEOUT_CYC    = 65536,
  parameter int AUTO_RETRY     = 1,
  parameter int AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ready_sample,
  input  logic [23:0] adc045_data,
  output logic        rst_l_adc,
  output logic        hard_wreg,
  output logic        hard_start,
  output logic [23:0] sample_data,
  output logic        sample_valid,
  output logic [15:0] sample_cnt,
  output logic        busy,
  output logic        fault,
  output logic [7:0]  fault_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_ASSERT = 3'd1,
    RST_WAIT   = 3'd2,
    WREG       = 3'd3,
    WREG_WAIT  = 3'd4,
    RUN        = 3'd5,
    FAULT      = 3'd6
  } state_t;

  function automatic int max2_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SEQ_MAX = max2_f(max2_f(RST_PULSE_CYC, RST_WAIT_CYC),
                                  max2_f(WREG_PULSE_CYC, WREG_WAIT_CYC));
  localparam int SEQ_W   = $clog2(SEQ_MAX) + 1;
  localparam int WD_W    = $clog2(TIMEOUT_CYC) + 1;

  state_t            state_r;
  state_t            next_state_s;
  logic [SEQ_W-1:0]  seq_cnt_r;
  logic [WD_W-1:0]   wd_cnt_r;
  logic              ready_r;
  logic              ready_prev_r;
  logic [23:0]       data_r;
  logic              seq_zero_s;
  logic              rise_s;
  logic              wd_expired_s;
  logic              take_s;

  // The shared counter is loaded with (cycles - 1) so a state lasts exactly its parameter.
  function automatic logic [SEQ_W-1:0] load_f(input state_t s);
    case (s)
      RST_ASSERT: return SEQ_W'(RST_PULSE_CYC - 1);
      RST_WAIT:   return SEQ_W'(RST_WAIT_CYC - 1);
      WREG:       return SEQ_W'(WREG_PULSE_CYC - 1);
      WREG_WAIT:  return SEQ_W'(WREG_WAIT_CYC - 1);
      FAULT:      return SEQ_W'(RST_PULSE_CYC - 1);
      default:    return {SEQ_W{1'b0}};
    endcase
  endfunction

  assign seq_zero_s   = (seq_cnt_r == {SEQ_W{1'b0}});
  assign rise_s       = ready_r & ~ready_prev_r;
  assign wd_expired_s = (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
  assign take_s       = (state_r == RUN) && (next_state_s == RUN) && rise_s;
  assign state        = state_r;

  // Next-state decode; a rise in the final watchdog cycle keeps the FSM in RUN.
  always_comb begin
    next_state_s = state_r;
    if (!enable) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:       next_state_s = RST_ASSERT;
        RST_ASSERT: next_state_s = seq_zero_s ? RST_WAIT : RST_ASSERT;
        RST_WAIT:   next_state_s = seq_zero_s ? WREG : RST_WAIT;
        WREG:       next_state_s = seq_zero_s ? WREG_WAIT : WREG;
        WREG_WAIT:  next_state_s = seq_zero_s ? RUN : WREG_WAIT;
        RUN:        next_state_s = (wd_expired_s && !rise_s) ? FAULT : RUN;
        FAULT:      next_state_s = ((AUTO_RETRY != 0) && seq_zero_s) ? RST_ASSERT : FAULT;
        default:    next_state_s = IDLE;
      endcase
    end
  end

  // FSM state, sequencing counter and control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      seq_cnt_r  <= {SEQ_W{1'b0}};
      rst_l_adc  <= 1'b0;
      hard_wreg  <= 1'b0;
      hard_start <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_cnt  <= 8'd0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        seq_cnt_r <= load_f(next_state_s);
      end else if (!seq_zero_s) begin
        seq_cnt_r <= seq_cnt_r - {{(SEQ_W-1){1'b0}}, 1'b1};
      end
      rst_l_adc  <= (next_state_s == RST_WAIT) || (next_state_s == WREG) ||
                    (next_state_s == WREG_WAIT) || (next_state_s == RUN);
      hard_wreg  <= (next_state_s == WREG);
      hard_start <= (next_state_s == RUN);
      busy       <= (next_state_s != IDLE) && (next_state_s != FAULT);
      fault      <= (next_state_s == FAULT);
      if ((state_r == RUN) && (next_state_s == FAULT) && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

  // Input capture: data is sampled alongside the current ready level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r      <= 1'b0;
      ready_prev_r <= 1'b0;
      data_r       <= 24'd0;
    end else begin
      ready_r      <= ready_sample;
      ready_prev_r <= ready_r;
      data_r       <= adc045_data;
    end
  end

  // Watchdog counts RUN cycles since entry or since the last rise.
  always_ff @(posedge clk) begin
    if (rst || (state_r != RUN) || rise_s) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ADC045_AVG_EN
  localparam int ACC_W = 24 + AVG_LOG2;
  localparam int PH_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic signed [ACC_W-1:0] acc_avg_s;
  logic [PH_W-1:0]         phase_r;
  logic                    last_s;

  assign acc_sum_s = acc_r + ACC_W'(signed'(data_r));
  assign acc_avg_s = acc_sum_s >>> AVG_LOG2;
  assign last_s    = (phase_r == PH_W'((1 << AVG_LOG2) - 1));

  // Block averaging; any partial block is dropped whenever RUN is entered or left.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= {ACC_W{1'b0}};
      phase_r      <= {PH_W{1'b0}};
      sample_data  <= 24'd0;
      sample_valid <= 1'b0;
      sample_cnt   <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      if ((state_r != RUN) || (next_state_s != RUN)) begin
        acc_r   <= {ACC_W{1'b0}};
        phase_r <= {PH_W{1'b0}};
      end else if (take_s) begin
        if (last_s) begin
          acc_r        <= {ACC_W{1'b0}};
          phase_r      <= {PH_W{1'b0}};
          sample_data  <= 24'(acc_avg_s);
          sample_valid <= 1'b1;
          sample_cnt   <= sample_cnt + 16'd1;
        end else begin
          acc_r   <= acc_sum_s;
          phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end
`else
  // Pass-through capture of each sample on a rise in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data  <= 24'd0;
      sample_valid <= 1'b0;
      sample_cnt   <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      if (take_s) begin
        sample_data  <= data_r;
        sample_valid <= 1'b1;
        sample_cnt   <= sample_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
